updown_count_sequencer: RTL and testbench
=========================================

# updown_count_sequencer

Command-driven controller that sequences an up/down counter datapath. It accepts load, step-up, step-down and bounce commands over a valid/ready handshake. For each command it drives the counter's enable, direction and load controls cycle by cycle, and signals completion with a one-cycle `done` pulse. It sits between a register/command interface and the counter, so software-like agents can request exact count movements instead of toggling `up_down` by hand.

## Interface
- WIDTH, 4, counter and argument width; count is modulo 2^WIDTH
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
- cmd_op  input  2  00 STEP_UP, 01 STEP_DOWN, 10 LOAD, 11 BOUNCE
- cmd_arg  input  WIDTH  step count (STEP_*), load value (LOAD), upper limit L (BOUNCE)
- count  output  WIDTH  current counter value
- dir_up  output  1  direction applied on the current/last step (1 = up)
- busy  output  1  high in RUN or SWEEP
- done  output  1  one-cycle pulse when a command completes
- wrap  output  1  one-cycle pulse coincident with a max→0 or 0→max transition

## Operation
- States: IDLE, RUN (STEP_*), SWEEP_UP, SWEEP_DOWN (BOUNCE).
- Accept: `cmd_valid && cmd_ready` at a rising edge. Command fields are sampled only then.
- LOAD: count ← cmd_arg at the accept edge. `done` is high in the following cycle. State stays IDLE.
- STEP_UP/STEP_DOWN, arg N:
  - N = 0: count unchanged, `done` in the following cycle, stays IDLE.
  - N > 0: enter RUN and latch remaining = N and the direction. Count moves ±1 on each of the next N edges. On the Nth step, `done` is set and the state returns to IDLE.
- BOUNCE, limit L, current value c:
  - If c < L, enter SWEEP_UP. Count up until count == L, then SWEEP_DOWN.
  - If c ≥ L, enter SWEEP_DOWN directly.
  - SWEEP_DOWN counts down to 0. The edge that reaches 0 sets `done` and returns to IDLE.
  - If c = 0 and L = 0, the command completes like N = 0.
  - Total steps: (L−c)+L for c < L; c otherwise. BOUNCE never wraps.
- Arithmetic: count ± 1 modulo 2^WIDTH. `wrap` is set on the edge that moves 2^WIDTH−1→0 (up) or 0→2^WIDTH−1 (down).
- `dir_up` holds its last value in IDLE. A LOAD does not change it.
- `cmd_valid` while busy is ignored: no accept, no side effects.

## Timing
- Reset values: count = 0, dir_up = 1, cmd_ready = 1 (IDLE), busy = 0, done = 0, wrap = 0, state IDLE.
- Reset mid-command aborts immediately. No `done` is produced.
- Latency:
  - First count change occurs one edge after accept.
  - STEP N completes N edges after accept. `done` is coincident with the final count value.
  - `cmd_ready` returns high in that same cycle.
- Back-to-back: the next command can be accepted on the edge after `done` rises.
- `done`, `wrap` and `count` are registered outputs. `cmd_ready` and `busy` are decoded from registered state only.

## Configuration
- Macro UDSEQ_BOUNCE_EN.
  - Defined: BOUNCE operates as specified.
  - Undefined: SWEEP states are not built. Op 11 is accepted as a NOP: count and dir_up are unchanged, `done` is high in the next cycle.

## Structure
- Package `updown_seq_pkg`: op encoding constants (OP_STEP_UP, OP_STEP_DOWN, OP_LOAD, OP_BOUNCE) and the state enumeration typedef.
- Sub-module `updown_count_core`: WIDTH-bit register with en, up_down, load, load_val and a registered wrap output. This is the datapath.
- The sequencer top holds the FSM, the remaining-steps counter, and the limit register.

## Test plan
- Reset, then LOAD 5 → count = 5 next cycle, `done` one cycle, dir_up = 1.
- From 14, STEP_UP 3 → count 15, 0, 1 on consecutive edges. `wrap` only with the 15→0 edge. `done` with count = 1. `busy` high for 3 cycles.
- From 0, STEP_DOWN 0 → count stays 0, `done` next cycle, no `wrap`. Then STEP_DOWN 1 → count = 15, `wrap` = 1.
- BOUNCE:
  - From 2, BOUNCE L = 4 → 3, 4, 3, 2, 1, 0 (6 steps), `done` with 0.
  - From 9, BOUNCE L = 4 → straight down to 0 in 9 steps.
  - Without UDSEQ_BOUNCE_EN → NOP with `done`.
- Hold `cmd_valid` with a new op during a STEP_UP 4 → not accepted until `done`, then accepted on the next edge.
- Assert reset mid-STEP_DOWN → count = 0, IDLE, no `done`.

Source files
------------

// File: rtl/updown_count_sequencer_pkg.sv
// rtl/updown_count_sequencer_pkg.sv - op encodings and FSM state type for the up/down count sequencer
package updown_seq_pkg;

  localparam logic [1:0] OP_STEP_UP   = 2'b00;
  localparam logic [1:0] OP_STEP_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD      = 2'b10;
  localparam logic [1:0] OP_BOUNCE    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RUN        = 2'd1,
    S_SWEEP_UP   = 2'd2,
    S_SWEEP_DOWN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/updown_count_sequencer_if.sv
// rtl/updown_count_sequencer_if.sv - command handshake and counter status bundle
interface updown_count_sequencer_if #(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [WIDTH-1:0] count;
  logic             dir_up;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, count, dir_up, busy, done, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, count, dir_up, busy, done, wrap
  );

endinterface

// File: rtl/updown_count_core.sv
// rtl/updown_count_core.sv - WIDTH-bit up/down counter datapath with load and registered wrap flag
module updown_count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // load wins over a step; wrap only flags a real +/-1 crossing, never a load
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (up_down_i) begin
        count_d = count_q + WIDTH'(1);
        wrap_d  = (count_q == CNT_MAX);
      end else begin
        count_d = count_q - WIDTH'(1);
        wrap_d  = (count_q == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/updown_count_sequencer.sv
// rtl/updown_count_sequencer.sv - FSM sequencing updown_count_core per command; BOUNCE built only with UDSEQ_BOUNCE_EN
module updown_count_sequencer
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                     clk,
  input logic                     reset,
  updown_count_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE       = S_IDLE;
  localparam logic [1:0] RUN        = S_RUN;
`ifdef UDSEQ_BOUNCE_EN
  localparam logic [1:0] SWEEP_UP   = S_SWEEP_UP;
  localparam logic [1:0] SWEEP_DOWN = S_SWEEP_DOWN;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
`ifdef UDSEQ_BOUNCE_EN
  logic [WIDTH-1:0] limit_q, limit_d;
`endif

  logic             core_en, core_up, core_load;
  logic [WIDTH-1:0] core_count;
  logic             core_wrap;

  updown_count_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .en_i       (core_en),
    .up_down_i  (core_up),
    .load_i     (core_load),
    .load_val_i (bus.cmd_arg),
    .count_o    (core_count),
    .wrap_o     (core_wrap)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    core_en     = 1'b0;
    core_up     = dir_q;
    core_load   = 1'b0;
`ifdef UDSEQ_BOUNCE_EN
    limit_d     = limit_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_LOAD: begin
              core_load = 1'b1;
              done_d    = 1'b1;
            end
            OP_STEP_UP, OP_STEP_DOWN: begin
              if (bus.cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = RUN;
                remaining_d = bus.cmd_arg;
                dir_d       = (bus.cmd_op == OP_STEP_UP);
              end
            end
            default: begin
`ifdef UDSEQ_BOUNCE_EN
              // at/above the limit the sweep is a plain descent to zero
              if (bus.cmd_arg == '0 && core_count == '0) begin
                done_d = 1'b1;
              end else if (core_count < bus.cmd_arg) begin
                state_d = SWEEP_UP;
                dir_d   = 1'b1;
                limit_d = bus.cmd_arg;
              end else begin
                state_d = SWEEP_DOWN;
                dir_d   = 1'b0;
              end
`else
              done_d = 1'b1;
`endif
            end
          endcase
        end
      end
      RUN: begin
        core_en     = 1'b1;
        core_up     = dir_q;
        remaining_d = remaining_q - WIDTH'(1);
        if (remaining_q == WIDTH'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef UDSEQ_BOUNCE_EN
      SWEEP_UP: begin
        core_en = 1'b1;
        core_up = 1'b1;
        dir_d   = 1'b1;
        if (core_count == limit_q - WIDTH'(1)) begin
          state_d = SWEEP_DOWN;
        end
      end
      SWEEP_DOWN: begin
        core_en = 1'b1;
        core_up = 1'b0;
        dir_d   = 1'b0;
        if (core_count == WIDTH'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b1;
      done_q      <= 1'b0;
`ifdef UDSEQ_BOUNCE_EN
      limit_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
`ifdef UDSEQ_BOUNCE_EN
      limit_q     <= limit_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.count     = core_count;
  assign bus.dir_up    = dir_q;
  assign bus.done      = done_q;
  assign bus.wrap      = core_wrap;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// tb/tb_updown_count_sequencer.sv - scoreboard bench for updown_count_sequencer
module tb_updown_count_sequencer;
  import updown_seq_pkg::*;

  typedef struct packed {
    logic [3:0] count;
    logic       done;
    logic       wrap;
    logic       busy;
    logic       dir;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  logic [3:0] m_count;
  logic       m_dir;

  updown_count_sequencer_if #(.WIDTH(4)) bus ();

  updown_count_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push(logic [3:0] c, logic d, logic w, logic b, logic dir);
    exp_t e;
    e.count = c; e.done = d; e.wrap = w; e.busy = b; e.dir = dir;
    sb.push_back(e);
  endfunction

  function automatic void step(logic up, logic last);
    logic [3:0] prev;
    logic       w;
    prev    = m_count;
    m_count = up ? prev + 4'd1 : prev - 4'd1;
    w       = up ? (prev == 4'hf) : (prev == 4'h0);
    m_dir   = up;
    push(m_count, last, w, !last, up);
  endfunction

  // expected per-cycle trace starting at the negedge right after the accept edge
  function automatic void model(logic [1:0] op, logic [3:0] arg);
    logic [3:0] c;
    int ups, downs;
    c = m_count;
    case (op)
      OP_LOAD: begin
        m_count = arg;
        push(arg, 1'b1, 1'b0, 1'b0, m_dir);
      end
      OP_STEP_UP, OP_STEP_DOWN: begin
        if (arg == 4'd0) begin
          push(c, 1'b1, 1'b0, 1'b0, m_dir);
        end else begin
          push(c, 1'b0, 1'b0, 1'b1, op == OP_STEP_UP);
          for (int i = 1; i <= int'(arg); i++) step(op == OP_STEP_UP, i == int'(arg));
        end
      end
      default: begin
`ifdef UDSEQ_BOUNCE_EN
        if (c == 4'd0 && arg == 4'd0) begin
          push(c, 1'b1, 1'b0, 1'b0, m_dir);
        end else begin
          ups   = (c < arg) ? int'(arg) - int'(c) : 0;
          downs = (c < arg) ? int'(arg) : int'(c);
          push(c, 1'b0, 1'b0, 1'b1, ups > 0);
          for (int i = 0; i < ups; i++) step(1'b1, 1'b0);
          for (int i = 0; i < downs; i++) step(1'b0, i == downs - 1);
        end
`else
        push(c, 1'b1, 1'b0, 1'b0, m_dir);
`endif
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [3:0] arg, input bit hold = 1'b0);
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    while (!bus.cmd_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      check("accept_timeout", {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(op, arg);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      e = sb.pop_front();
      check("count",  {28'd0, bus.count}, {28'd0, e.count});
      check("done",   {31'd0, bus.done},  {31'd0, e.done});
      check("wrap",   {31'd0, bus.wrap},  {31'd0, e.wrap});
      check("busy",   {31'd0, bus.busy},  {31'd0, e.busy});
      check("ready",  {31'd0, bus.cmd_ready}, {31'd0, !e.busy});
      check("dir_up", {31'd0, bus.dir_up}, {31'd0, e.dir});
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [3:0] arg);
    issue(op, arg);
    drain(sb.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_count = 4'd0;
    m_dir = 1'b1;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_arg = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_count", {28'd0, bus.count}, 32'd0);
    check("rst_dir",   {31'd0, bus.dir_up}, 32'd1);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_wrap",  {31'd0, bus.wrap}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(OP_LOAD, 4'd5);
    run(OP_LOAD, 4'd14);
    run(OP_STEP_UP, 4'd3);
    run(OP_LOAD, 4'd0);
    run(OP_STEP_DOWN, 4'd0);
    run(OP_STEP_DOWN, 4'd1);

    run(OP_LOAD, 4'd2);
    run(OP_BOUNCE, 4'd4);
    run(OP_LOAD, 4'd9);
    run(OP_BOUNCE, 4'd4);
    run(OP_BOUNCE, 4'd0);
    run(OP_LOAD, 4'd4);
    run(OP_BOUNCE, 4'd4);

    // a LOAD held on the bus while STEP_UP 4 runs must wait for done
    run(OP_LOAD, 4'd3);
    issue(OP_STEP_UP, 4'd4, 1'b1);
    bus.cmd_op  = OP_LOAD;
    bus.cmd_arg = 4'd7;
    drain(sb.size());
    run(OP_LOAD, 4'd7);

    for (int k = 0; k < 6; k++) begin
      run(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    // async reset in the middle of a STEP_DOWN aborts without done
    run(OP_LOAD, 4'd8);
    issue(OP_STEP_DOWN, 4'd5);
    drain(3);
    sb.delete();
    #2 reset = 1'b1;
    #1;
    check("abort_count", {28'd0, bus.count}, 32'd0);
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("abort_done",  {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_count = 4'd0;
    m_dir = 1'b1;
    @(negedge clk);
    check("post_abort_done",  {31'd0, bus.done}, 32'd0);
    check("post_abort_count", {28'd0, bus.count}, 32'd0);
    check("post_abort_dir",   {31'd0, bus.dir_up}, 32'd1);
    run(OP_STEP_UP, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
